logic_gate_pipe: RTL and testbench

LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

---
 rtl/logic_gate_pipe_pkg.sv | 24 ++
 rtl/pipe_stage.sv | 43 ++++
 rtl/logic_gate_pipe.sv | 112 +++++++++++
 tb/tb_logic_gate_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pipe_pkg.sv
// Shared definitions for the two-stage bitwise logic pipeline:
// operation encodings, the illegal-operation code and a decode helper.
package logic_gate_pipe_pkg;

    typedef enum logic [2:0] {
        OP_AND     = 3'd0,
        OP_OR      = 3'd1,
        OP_XOR     = 3'd2,
        OP_NAND    = 3'd3,
        OP_NOR     = 3'd4,
        OP_XNOR    = 3'd5,
        OP_PASS_A  = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    localparam logic [2:0] OP_ILLEGAL_CODE = 3'd7;
    localparam int         OP_W            = 3;

    // True when the operation code selects a defined gate function.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op != OP_ILLEGAL_CODE);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register with its own valid bit and a ready that is
// combinational from the downstream ready, so a full pipeline can
// accept a new item in the same cycle the sink drains one.
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         valid_r;
    logic [W-1:0] data_r;

    // Ready when empty or when the current item is leaving this cycle.
    assign in_ready  = (!valid_r) || out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Advance when ready; otherwise hold payload and valid stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (in_ready) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end else begin
                data_r <= data_r;
            end
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipeline applying a bitwise gate to A and B.
// Stage 1 holds the operands, stage 2 holds the result together with
// its reductions and the illegal-operation flag.
module logic_gate_pipe
    import logic_gate_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] Y,
    output logic             Y_VALID,
    input  logic             Y_READY,
    output logic             RED_AND,
    output logic             RED_OR,
    output logic             ERR,
    output logic [CNT_W-1:0] DONE_CNT
);

    localparam int S1_W = OP_W + 2 * WIDTH;
    localparam int S2_W = WIDTH + 3;

    // Bitwise gate evaluation; the illegal code yields all zeros.
    function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0]       op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_NAND:   r = ~(a & b);
            OP_NOR:    r = ~(a | b);
            OP_XNOR:   r = ~(a ^ b);
            OP_PASS_A: r = a;
            default:   r = '0;
        endcase
        return r;
    endfunction

    logic [S1_W-1:0]  s1_in_s;
    logic [S1_W-1:0]  s1_data_s;
    logic             s1_valid_s;
    logic [S2_W-1:0]  s2_in_s;
    logic [S2_W-1:0]  s2_data_s;
    logic             s2_ready_s;
    logic [2:0]       s1_op_s;
    logic [WIDTH-1:0] s1_a_s;
    logic [WIDTH-1:0] s1_b_s;
    logic [WIDTH-1:0] res_s;
    logic             err_s;
    logic [CNT_W-1:0] done_cnt_r;

    assign s1_in_s = {OP, A, B};

    pipe_stage #(.W(S1_W)) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (IN_VALID),
        .in_data   (s1_in_s),
        .in_ready  (IN_READY),
        .out_valid (s1_valid_s),
        .out_data  (s1_data_s),
        .out_ready (s2_ready_s)
    );

    // Compute the result, flag and reductions from the stage-1 operands.
    always_comb begin
        s1_op_s = s1_data_s[S1_W-1 -: OP_W];
        s1_a_s  = s1_data_s[2*WIDTH-1 -: WIDTH];
        s1_b_s  = s1_data_s[WIDTH-1:0];
        res_s   = gate_eval(s1_op_s, s1_a_s, s1_b_s);
        err_s   = !is_legal_op(s1_op_s);
        s2_in_s = {err_s, |res_s, &res_s, res_s};
    end

    pipe_stage #(.W(S2_W)) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid_s),
        .in_data   (s2_in_s),
        .in_ready  (s2_ready_s),
        .out_valid (Y_VALID),
        .out_data  (s2_data_s),
        .out_ready (Y_READY)
    );

    assign Y        = s2_data_s[WIDTH-1:0];
    assign RED_AND  = s2_data_s[WIDTH];
    assign RED_OR   = s2_data_s[WIDTH+1];
    assign ERR      = s2_data_s[WIDTH+2];
    assign DONE_CNT = done_cnt_r;

    // Count output transfers; wraps naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_r <= '0;
        end else if (Y_VALID && Y_READY) begin
            done_cnt_r <= done_cnt_r + CNT_W'(1);
        end else begin
            done_cnt_r <= done_cnt_r;
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed testbench for logic_gate_pipe (WIDTH=8, CNT_W=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_logic_gate_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [2:0] OP = 3'd0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [7:0] Y;
    logic       Y_VALID;
    logic       Y_READY = 1'b0;
    logic       RED_AND;
    logic       RED_OR;
    logic       ERR;
    logic [3:0] DONE_CNT;

    int checks = 0;
    int errs   = 0;
    logic [3:0] exp_cnt = 4'd0;
    logic       seen_ready;
    logic       seen_mid_valid;

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .OP       (OP),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .Y        (Y),
        .Y_VALID  (Y_VALID),
        .Y_READY  (Y_READY),
        .RED_AND  (RED_AND),
        .RED_OR   (RED_OR),
        .ERR      (ERR),
        .DONE_CNT (DONE_CNT)
    );

    // Drive one transaction with Y_READY=1 and leave the bench at the
    // falling edge after the second rising edge, where the result shows.
    task automatic send_one(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        Y_READY  = 1'b1;
        OP       = op;
        A        = a;
        B        = b;
        IN_VALID = 1'b1;
        #1 seen_ready = IN_READY;
        @(negedge clk);
        IN_VALID = 1'b0;
        OP       = 3'd7;
        A        = 8'h5A;
        B        = 8'hA5;
        seen_mid_valid = Y_VALID;
        @(negedge clk);
        exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        IN_VALID = 1'b0;
        Y_READY  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 4'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({Y_VALID, Y, RED_AND, RED_OR, ERR, DONE_CNT} !== 16'h0000) begin
            errs++;
            $display("FAIL reset_outputs: got Y_VALID=%b Y=%h RA=%b RO=%b ERR=%b CNT=%0d, want all zero",
                     Y_VALID, Y, RED_AND, RED_OR, ERR, DONE_CNT);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errs++;
            $display("FAIL reset_in_ready: got %b want 1", IN_READY);
        end
    endtask

    task automatic test_truth_table();
        logic [7:0] exp_y [7] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0};
        for (int i = 0; i < 7; i++) begin
            send_one(3'(i), 8'hF0, 8'hCC);
            checks++;
            if (seen_ready !== 1'b1 || seen_mid_valid !== 1'b0) begin
                errs++;
                $display("FAIL tt_latency op=%0d: in_ready=%b mid_valid=%b want 1/0", i, seen_ready, seen_mid_valid);
            end
            checks++;
            if (Y_VALID !== 1'b1 || Y !== exp_y[i] || ERR !== 1'b0) begin
                errs++;
                $display("FAIL tt_result op=%0d: got v=%b Y=%h ERR=%b want v=1 Y=%h ERR=0", i, Y_VALID, Y, ERR, exp_y[i]);
            end
        end
    endtask

    task automatic test_illegal();
        send_one(3'd7, 8'hFF, 8'hFF);
        checks++;
        if (Y_VALID !== 1'b1 || Y !== 8'h00 || ERR !== 1'b1 || RED_OR !== 1'b0 || RED_AND !== 1'b0) begin
            errs++;
            $display("FAIL illegal_op: got v=%b Y=%h ERR=%b RO=%b RA=%b want 1 00 1 0 0", Y_VALID, Y, ERR, RED_OR, RED_AND);
        end
    endtask

    task automatic test_reductions();
        send_one(3'd0, 8'hFF, 8'hFF);
        checks++;
        if (Y !== 8'hFF || RED_AND !== 1'b1 || RED_OR !== 1'b1 || ERR !== 1'b0) begin
            errs++;
            $display("FAIL red_ones: got Y=%h RA=%b RO=%b ERR=%b want FF 1 1 0", Y, RED_AND, RED_OR, ERR);
        end
        send_one(3'd0, 8'h01, 8'h01);
        checks++;
        if (Y !== 8'h01 || RED_AND !== 1'b0 || RED_OR !== 1'b1) begin
            errs++;
            $display("FAIL red_one_bit: got Y=%h RA=%b RO=%b want 01 0 1", Y, RED_AND, RED_OR);
        end
        @(negedge clk);
        checks++;
        if (DONE_CNT !== exp_cnt || Y_VALID !== 1'b0) begin
            errs++;
            $display("FAIL count_after_singles: got cnt=%0d v=%b want cnt=%0d v=0", DONE_CNT, Y_VALID, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        // item 0: XOR -> 3C, item 1: AND -> C0, item 2: OR -> FC
        @(negedge clk);
        Y_READY = 1'b0; OP = 3'd2; A = 8'hF0; B = 8'hCC; IN_VALID = 1'b1;
        #1 checks++;
        if (IN_READY !== 1'b1) begin
            errs++;
            $display("FAIL bp_accept0: in_ready=%b want 1", IN_READY);
        end
        @(negedge clk);
        OP = 3'd0;
        #1 checks++;
        if (IN_READY !== 1'b1) begin
            errs++;
            $display("FAIL bp_accept1: in_ready=%b want 1", IN_READY);
        end
        @(negedge clk);
        OP = 3'd1;
        for (int c = 0; c < 5; c++) begin
            #1 checks++;
            if (IN_READY !== 1'b0 || Y_VALID !== 1'b1 || Y !== 8'h3C || ERR !== 1'b0) begin
                errs++;
                $display("FAIL bp_hold cycle %0d: rdy=%b v=%b Y=%h want 0 1 3C", c, IN_READY, Y_VALID, Y);
            end
            @(negedge clk);
        end
        Y_READY = 1'b1;
        #1 checks++;
        if (IN_READY !== 1'b1) begin
            errs++;
            $display("FAIL bp_ready_same_cycle: in_ready=%b want 1", IN_READY);
        end
        @(negedge clk);
        IN_VALID = 1'b0;
        checks++;
        if (Y_VALID !== 1'b1 || Y !== 8'hC0) begin
            errs++;
            $display("FAIL bp_drain1: v=%b Y=%h want 1 C0", Y_VALID, Y);
        end
        @(negedge clk);
        checks++;
        if (Y_VALID !== 1'b1 || Y !== 8'hFC) begin
            errs++;
            $display("FAIL bp_drain2: v=%b Y=%h want 1 FC", Y_VALID, Y);
        end
        @(negedge clk);
        checks++;
        if (Y_VALID !== 1'b0 || DONE_CNT !== 4'd3) begin
            errs++;
            $display("FAIL bp_empty: v=%b cnt=%0d want 0 3", Y_VALID, DONE_CNT);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int n = 0; n < 19; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                checks++;
                if (Y_VALID !== 1'b1 || Y !== (8'(n - 2) ^ 8'h55)) begin
                    errs++;
                    $display("FAIL stream item %0d: v=%b Y=%h want 1 %h", n - 2, Y_VALID, Y, 8'(n - 2) ^ 8'h55);
                end
            end
            Y_READY = 1'b1;
            if (n < 17) begin
                OP = 3'd2; A = 8'(n); B = 8'h55; IN_VALID = 1'b1;
                #1 checks++;
                if (IN_READY !== 1'b1) begin
                    errs++;
                    $display("FAIL stream_ready %0d: in_ready=%b want 1", n, IN_READY);
                end
            end else begin
                IN_VALID = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (DONE_CNT !== 4'd1 || Y_VALID !== 1'b0) begin
            errs++;
            $display("FAIL stream_count: cnt=%0d v=%b want 1 0", DONE_CNT, Y_VALID);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        Y_READY = 1'b0; OP = 3'd1; A = 8'h11; B = 8'h22; IN_VALID = 1'b1;
        @(negedge clk);
        OP = 3'd6;
        @(negedge clk);
        IN_VALID = 1'b0;
        checks++;
        if (Y_VALID !== 1'b1 || DONE_CNT !== 4'd1) begin
            errs++;
            $display("FAIL mid_setup: v=%b cnt=%0d want 1 1", Y_VALID, DONE_CNT);
        end
        #2 rst_n = 1'b0;
        #1 checks++;
        if (Y_VALID !== 1'b0 || DONE_CNT !== 4'd0 || Y !== 8'h00) begin
            errs++;
            $display("FAIL mid_async_clear: v=%b cnt=%0d Y=%h want 0 0 00", Y_VALID, DONE_CNT, Y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        Y_READY = 1'b1;
        #1 checks++;
        if (IN_READY !== 1'b1) begin
            errs++;
            $display("FAIL mid_ready_after: in_ready=%b want 1", IN_READY);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (Y_VALID !== 1'b0 || DONE_CNT !== 4'd0) begin
                errs++;
                $display("FAIL mid_no_stale cycle %0d: v=%b cnt=%0d want 0 0", c, Y_VALID, DONE_CNT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_illegal();
        test_reductions();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule
